lsu_multibeat: RTL and testbench
================================

// Module: lsu_multibeat
// PURPOSE
//  Parametrised load/store unit: multi-byte load/store/push/pop over an internal byte-wide sync-read RAM.
//  Handshaked request port, single-cycle response pulse, built-in descending stack pointer.
//  Sits between decode/execute and memory; replaces single-byte LSU accesses for WORD_BYTES-wide operands.
// PARAMETERS
//  AW           16   address width; RAM depth = 2**AW bytes; all address arithmetic modulo 2**AW
//  WORD_BYTES   4    bytes per transfer (1..4); DW = 8*WORD_BYTES
//  SP_RESET     0    stack pointer value after reset (0 = empty, full-descending)
//  STACK_BYTES  256  stack capacity in bytes (used only with LSU_STACK_CHECK_EN)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    synchronous reset, active-low
//  req_valid  in   1    request present
//  req_ready  out  1    request accepted when req_valid & req_ready
//  req_op     in   2    00 LOAD, 01 STORE, 10 PUSH, 11 POP
//  req_addr   in   AW   byte address for LOAD/STORE (ignored for PUSH/POP)
//  req_wdata  in   DW   store/push data, little-endian
//  sp_we      in   1    load sp from sp_d
//  sp_d       in   AW   new stack pointer value
//  rsp_valid  out  1    one-cycle pulse: request complete
//  rsp_rdata  out  DW   LOAD/POP data; valid with rsp_valid, held until next response
//  rsp_fault  out  1    stack over/underflow; valid with rsp_valid
//  sp_q       out  AW   current stack pointer
// BEHAVIOUR
//  Reset (rst low at edge): state IDLE, beat=0, sp_q=SP_RESET, rsp_valid=0, rsp_rdata=0, rsp_fault=0;
//   req_ready=0 while rst low. RAM contents NOT cleared. Reset mid-operation aborts: no response, partial bytes stay written.
//  FSM: IDLE -> ACCESS (beats 0..WORD_BYTES-1) -> DONE -> IDLE.
//  req_ready = rst & (state==IDLE) & ~sp_we. Request latched (op, ea, wdata) on accept.
//  Effective address ea: LOAD/STORE = req_addr; PUSH = sp_q-WORD_BYTES; POP = sp_q.
//  sp update on accept: PUSH sp<=sp-WORD_BYTES; POP sp<=sp+WORD_BYTES; modulo 2**AW.
//  ACCESS beat i: RAM address = ea+i (wraps past 2**AW-1 to 0); write wdata[8i+:8] (STORE/PUSH)
//   or read; read byte from beat i captured into rdata[8i+:8] the following cycle.
//  DONE: captures last read byte, asserts rsp_valid for exactly one cycle; next cycle IDLE.
//  Latency accept -> rsp_valid = WORD_BYTES+1 cycles, all ops; next accept earliest cycle after rsp_valid.
//  STORE/PUSH responses: rsp_rdata unchanged.
//  sp_we: honoured only in IDLE; has priority over a same-cycle req_valid (req_ready=0 that cycle).
//   sp_we outside IDLE ignored. RAM port idle when not in ACCESS.
// CONFIGURATION
//  LSU_STACK_CHECK_EN defined: stack byte count cnt (0..STACK_BYTES), reset 0, cleared by sp_we.
//   PUSH with cnt+WORD_BYTES>STACK_BYTES, or POP with cnt<WORD_BYTES: faults.
//   Faulting request: accepted, no RAM access, sp/cnt unchanged, skips ACCESS; rsp_valid+rsp_fault=1
//   one cycle after accept; rsp_rdata unchanged. Otherwise cnt +=/-= WORD_BYTES on accept.
//  Not defined: no counter, sp wraps freely, rsp_fault tied 0.
// TESTING (WORD_BYTES=4, AW=16)
//  Reset held 2 cycles then released -> sp_q=0x0000, rsp_valid=0, req_ready=1 the next cycle.
//  STORE 0x44332211 @0x0010, then LOAD @0x0010 -> rdata 0x44332211; rsp_valid exactly 5 cycles after each accept.
//  STORE 0xDDCCBBAA @0xFFFE; LOAD @0x0000 -> 0x????DDCC (upper bytes untouched), LOAD @0xFFFE -> 0xDDCCBBAA.
//  PUSH 0xA, PUSH 0xB -> sp 0xFFFC, 0xFFF8; POP -> 0xB, POP -> 0xA, sp 0x0000.
//  sp_we=1, sp_d=0x1000 with req_valid=1 same cycle -> req_ready=0, sp_q=0x1000 next cycle, request accepted one cycle later.
//  LSU_STACK_CHECK_EN: POP after reset -> rsp_valid+rsp_fault=1 one cycle after accept, sp_q stays 0x0000;
//   64 PUSHes ok, 65th faults.

Source files
------------

// File: rtl/lsu_multibeat_if.sv
// Request/response/stack-pointer bundle between an execute stage (master) and lsu_multibeat (slave).
// Pure wiring; no latency. The request side uses valid/ready, the response is a single-cycle pulse.
interface lsu_multibeat_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          sp_we;
    logic [AW-1:0] sp_d;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_fault;
    logic [AW-1:0] sp_q;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, sp_we, sp_d,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, sp_q
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, sp_we, sp_d,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, sp_q
    );
endinterface

// File: rtl/lsu_multibeat.sv
// Multi-byte load/store/push/pop over a byte-wide sync-read RAM with a descending SP; LSU_STACK_CHECK_EN adds over/underflow faults.
// Latency: accept -> rsp_valid is WORD_BYTES+1 cycles (1 cycle for a faulting stack op).
// Backpressure: req_ready only in IDLE with no sp_we, so one request is in flight at a time.
module lsu_multibeat #(
    parameter int            AW          = 16,
    parameter int            WORD_BYTES  = 4,
    parameter logic [AW-1:0] SP_RESET    = '0,
    parameter int            STACK_BYTES = 256
) (
    input logic            clk,
    input logic            rst,
    lsu_multibeat_if.slave bus
);
    localparam int            DW = 8 * WORD_BYTES;
    localparam int            BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [AW-1:0] WB = AW'(WORD_BYTES);
    localparam logic [1:0]    OP_LOAD  = 2'b00;
    localparam logic [1:0]    OP_STORE = 2'b01;
    localparam logic [1:0]    OP_PUSH  = 2'b10;
    localparam logic [1:0]    OP_POP   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [AW-1:0] stk_ptr_q, stk_ptr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    ram_dout_q;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wbyte;

    logic          accept, req_fault, is_rd;
    logic [DW-1:0] load_word;
    int            prev_idx;

    assign bus.req_ready = rst && (state_q == S_IDLE) && !bus.sp_we;
    assign accept        = bus.req_valid && bus.req_ready;
    assign is_rd         = (op_q == OP_LOAD) || (op_q == OP_POP);

`ifdef LSU_STACK_CHECK_EN
    localparam int CW = $clog2(STACK_BYTES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        req_fault = 1'b0;
        if (bus.req_op == OP_PUSH)
            req_fault = (int'(cnt_q) + WORD_BYTES) > STACK_BYTES;
        else if (bus.req_op == OP_POP)
            req_fault = int'(cnt_q) < WORD_BYTES;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && bus.sp_we)
            cnt_d = '0;
        else if (accept && !req_fault) begin
            if (bus.req_op == OP_PUSH)
                cnt_d = cnt_q + CW'(WORD_BYTES);
            else if (bus.req_op == OP_POP)
                cnt_d = cnt_q - CW'(WORD_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign req_fault = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        op_d      = op_q;
        ea_d      = ea_q;
        stk_ptr_d = stk_ptr_q;
        wdata_d   = wdata_q;
        acc_d     = acc_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = ea_q + AW'(beat_q);
        ram_wbyte = wdata_q[8*int'(beat_q) +: 8];
        prev_idx  = (beat_q == '0) ? 0 : int'(beat_q) - 1;
        // The last byte is still on the RAM output during DONE, so splice it in.
        load_word = acc_q;
        load_word[DW-1 -: 8] = ram_dout_q;

        case (state_q)
            S_IDLE: begin
                if (rst && bus.sp_we) begin
                    stk_ptr_d = bus.sp_d;
                end else if (accept) begin
                    op_d    = bus.req_op;
                    wdata_d = bus.req_wdata;
                    fault_d = req_fault;
                    beat_d  = '0;
                    case (bus.req_op)
                        OP_PUSH: ea_d = stk_ptr_q - WB;
                        OP_POP:  ea_d = stk_ptr_q;
                        default: ea_d = bus.req_addr;
                    endcase
                    if (!req_fault && bus.req_op == OP_PUSH) stk_ptr_d = stk_ptr_q - WB;
                    if (!req_fault && bus.req_op == OP_POP)  stk_ptr_d = stk_ptr_q + WB;
                    state_d = req_fault ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en = rst;
                ram_we = !is_rd;
                if (beat_q != '0 && is_rd)
                    acc_d[8*prev_idx +: 8] = ram_dout_q;
                if (beat_q == BW'(WORD_BYTES - 1))
                    state_d = S_DONE;
                else
                    beat_d = beat_q + 1'b1;
            end
            S_DONE: begin
                if (is_rd && !fault_q)
                    rdata_d = load_word;
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            op_q      <= OP_LOAD;
            ea_q      <= '0;
            stk_ptr_q <= SP_RESET;
            wdata_q   <= '0;
            acc_q     <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            op_q      <= op_d;
            ea_q      <= ea_d;
            stk_ptr_q <= stk_ptr_d;
            wdata_q   <= wdata_d;
            acc_q     <= acc_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wbyte;
            else        ram_dout_q    <= mem[ram_addr];
        end
    end

    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_fault = (state_q == S_DONE) && fault_q;
    assign bus.rsp_rdata = (state_q == S_DONE && is_rd && !fault_q) ? load_word : rdata_q;
    assign bus.sp_q      = stk_ptr_q;
endmodule

// File: tb/tb_lsu_multibeat.sv
// Bench for lsu_multibeat (WORD_BYTES=4, AW=16): directed table, multi-cycle corner sequences, random ops vs a byte-array model.
module tb_lsu_multibeat;
    localparam int         AW = 16;
    localparam int         WB = 4;
    localparam int         DW = 32;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lsu_multibeat_if #(.AW(AW), .DW(DW)) bus ();

    lsu_multibeat #(
        .AW(AW), .WORD_BYTES(WB), .SP_RESET(16'h0000), .STACK_BYTES(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] rd_mask;
        logic [15:0] exp_sp;
    } vec_t;

    vec_t        vecs [9];
    logic [7:0]  mem_m [0:65535];
    logic [31:0] rd;
    logic        flt;
    logic [15:0] sp_o;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_LOAD;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.sp_we     = 1'b0;
        bus.sp_d      = '0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_sp", 32'(bus.sp_q), 32'h0000);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        check("reset_rdata", bus.rsp_rdata, 32'd0);
        check("reset_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge following the response pulse.
    task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                          output logic [31:0] r, output logic f, output logic [15:0] s, output int l);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        #1;
        r = '0; f = 1'b0; s = bus.sp_q; l = -1;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            checks++; failures++;
            $display("FAIL accept_timeout: req_ready low for %0d cycles, need 1", n);
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        l = 1;
        while (!bus.rsp_valid && l < 20) begin
            @(negedge clk);
            l++;
        end
        if (!bus.rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, need one", l);
            l = -1;
            return;
        end
        r = bus.rsp_rdata;
        f = bus.rsp_fault;
        s = bus.sp_q;
        @(negedge clk);
        check("rsp_pulse_then_ready", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;
        logic [15:0] sp_m, a;
        logic [31:0] rd_m;
        logic [1:0]  op;
        int          depth, ok_cnt;
        logic        saw_rsp;

        vecs[0] = '{OP_STORE, 16'h0010, 32'h44332211, 32'h00000000, 32'hFFFFFFFF, 16'h0000};
        vecs[1] = '{OP_LOAD,  16'h0010, 32'h0,        32'h44332211, 32'hFFFFFFFF, 16'h0000};
        vecs[2] = '{OP_STORE, 16'hFFFE, 32'hDDCCBBAA, 32'h44332211, 32'hFFFFFFFF, 16'h0000};
        vecs[3] = '{OP_LOAD,  16'h0000, 32'h0,        32'h0000DDCC, 32'h0000FFFF, 16'h0000};
        vecs[4] = '{OP_LOAD,  16'hFFFE, 32'h0,        32'hDDCCBBAA, 32'hFFFFFFFF, 16'h0000};
        vecs[5] = '{OP_PUSH,  16'h0000, 32'h0000000A, 32'hDDCCBBAA, 32'hFFFFFFFF, 16'hFFFC};
        vecs[6] = '{OP_PUSH,  16'h1234, 32'h0000000B, 32'hDDCCBBAA, 32'hFFFFFFFF, 16'hFFF8};
        vecs[7] = '{OP_POP,   16'h0000, 32'h0,        32'h0000000B, 32'hFFFFFFFF, 16'hFFFC};
        vecs[8] = '{OP_POP,   16'h0000, 32'h0,        32'h0000000A, 32'hFFFFFFFF, 16'h0000};

        do_reset();

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, flt, sp_o, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_rdata", i), rd & vecs[i].rd_mask, vecs[i].exp_rd);
            check($sformatf("vec%0d_sp", i), 32'(sp_o), 32'(vecs[i].exp_sp));
            check($sformatf("vec%0d_fault", i), 32'(flt), 32'd0);
        end

        // sp_we wins over a same-cycle request; the request goes through one cycle later.
        bus.sp_we     = 1'b1;
        bus.sp_d      = 16'h1000;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_PUSH;
        bus.req_wdata = 32'hCAFEF00D;
        #1;
        check("ready_blocked_by_sp_we", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.sp_we = 1'b0;
        #1;
        check("sp_loaded", 32'(bus.sp_q), 32'h1000);
        check("ready_after_sp_we", 32'(bus.req_ready), 32'd1);
        do_req(OP_PUSH, 16'h0000, 32'hCAFEF00D, rd, flt, sp_o, lat);
        check("spwe_push_latency", 32'(lat), 32'd5);
        check("spwe_push_sp", 32'(sp_o), 32'h0FFC);

        // sp_we during an access is ignored.
        fork
            do_req(OP_POP, 16'h0000, 32'h0, rd, flt, sp_o, lat);
            begin
                repeat (2) @(negedge clk);
                bus.sp_we = 1'b1;
                bus.sp_d  = 16'h2222;
                @(negedge clk);
                bus.sp_we = 1'b0;
            end
        join
        check("busy_spwe_pop_rdata", rd, 32'hCAFEF00D);
        check("busy_spwe_pop_sp", 32'(sp_o), 32'h1000);
        check("busy_spwe_sp_after", 32'(bus.sp_q), 32'h1000);

        // Reset after two beats of a store: no response, first two bytes land.
        do_req(OP_STORE, 16'h0200, 32'hAAAAAAAA, rd, flt, sp_o, lat);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_STORE;
        bus.req_addr  = 16'h0200;
        bus.req_wdata = 32'h11223344;
        @(negedge clk);
        bus.req_valid = 1'b0;
        saw_rsp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            saw_rsp = saw_rsp | bus.rsp_valid;
        end
        check("abort_no_response", 32'(saw_rsp), 32'd0);
        check("abort_sp_reset", 32'(bus.sp_q), 32'h0000);
        do_req(OP_LOAD, 16'h0200, 32'h0, rd, flt, sp_o, lat);
        check("abort_partial_bytes", rd, 32'hAAAA3344);

`ifdef LSU_STACK_CHECK_EN
        do_reset();
        do_req(OP_POP, 16'h0000, 32'h0, rd, flt, sp_o, lat);
        check("underflow_latency", 32'(lat), 32'd1);
        check("underflow_fault", 32'(flt), 32'd1);
        check("underflow_sp", 32'(sp_o), 32'h0000);
        check("underflow_rdata", rd, 32'h0);
        ok_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            do_req(OP_PUSH, 16'h0000, 32'(i), rd, flt, sp_o, lat);
            if (!flt && lat == 5) ok_cnt++;
        end
        check("push64_ok", 32'(ok_cnt), 32'd64);
        do_req(OP_PUSH, 16'h0000, 32'hBAD0BAD0, rd, flt, sp_o, lat);
        check("overflow_latency", 32'(lat), 32'd1);
        check("overflow_fault", 32'(flt), 32'd1);
        check("overflow_sp", 32'(sp_o), 32'hFF00);
`endif

        // Random traffic against a byte-array model.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            a   = 16'hFFF0 + 16'(4 * k);
            exp = $urandom;
            for (int j = 0; j < 4; j++) mem_m[16'(a + 16'(j))] = exp[8*j +: 8];
            do_req(OP_STORE, a, exp, rd, flt, sp_o, lat);
        end
        sp_m  = 16'h0000;
        rd_m  = 32'h0;
        depth = 0;
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_POP && depth == 0) op = OP_PUSH;
            if (op == OP_PUSH && depth >= 16) op = OP_POP;
            a   = 16'hFFF0 + 16'($urandom_range(0, 31));
            exp = $urandom;
            case (op)
                OP_LOAD: for (int j = 0; j < 4; j++) rd_m[8*j +: 8] = mem_m[16'(a + 16'(j))];
                OP_STORE: for (int j = 0; j < 4; j++) mem_m[16'(a + 16'(j))] = exp[8*j +: 8];
                OP_PUSH: begin
                    sp_m = sp_m - 16'd4;
                    for (int j = 0; j < 4; j++) mem_m[16'(sp_m + 16'(j))] = exp[8*j +: 8];
                    depth++;
                end
                default: begin
                    for (int j = 0; j < 4; j++) rd_m[8*j +: 8] = mem_m[16'(sp_m + 16'(j))];
                    sp_m = sp_m + 16'd4;
                    depth--;
                end
            endcase
            do_req(op, a, exp, rd, flt, sp_o, lat);
            check($sformatf("rnd%0d_op%0d_rdata", i, op), rd, rd_m);
            check($sformatf("rnd%0d_op%0d_sp", i, op), 32'(sp_o), 32'(sp_m));
            check($sformatf("rnd%0d_op%0d_latency", i, op), 32'(lat), 32'd5);
            check($sformatf("rnd%0d_op%0d_fault", i, op), 32'(flt), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
